// File: rtl/multiplier.sv
// Two-stage pipelined unsigned multiplier, y = a * b at full 2*WORD_WIDTH precision.
// Stage 1 sums the low and high halves of the partial products; stage 2 merges them.
module multiplier #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [WORD_WIDTH-1:0]     a,
    input  logic [WORD_WIDTH-1:0]     b,
    output logic [2*WORD_WIDTH-1:0]   y,
    output logic                      out_valid
);

    localparam int W = WORD_WIDTH;
    localparam int H = W / 2;
    localparam int P = 2 * W;

    logic [P-1:0] lo_sum [0:H];
    logic [P-1:0] hi_sum [0:H];

    logic [P-1:0] plo;
    logic [P-1:0] phi;
    logic         v1;

    assign lo_sum[0] = '0;
    assign hi_sum[0] = '0;

    // hi rows use b[H+i] but are weighted as if b started at bit 0
    for (genvar i = 0; i < H; i++) begin : g_rows
        logic [P-1:0] lo_row;
        logic [P-1:0] hi_row;

        assign lo_row = {{W{1'b0}}, a & {W{b[i]}}} << i;
        assign hi_row = {{W{1'b0}}, a & {W{b[H+i]}}} << i;

        assign lo_sum[i+1] = lo_sum[i] + lo_row;
        assign hi_sum[i+1] = hi_sum[i] + hi_row;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plo <= '0;
            phi <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                plo <= lo_sum[H];
                phi <= hi_sum[H];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                y <= plo + (phi << H);
            end
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Randomised and directed checks of the pipelined multiplier at widths 4, 8 and 16
// against a cycle-level product model.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [15:0] y8;
    logic [7:0]  y4;
    logic [31:0] y16;
    logic        ov8;
    logic        ov4;
    logic        ov16;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    multiplier #(.WORD_WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .a(a8), .b(b8), .y(y8), .out_valid(ov8)
    );

    multiplier #(.WORD_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .a(a4), .b(b4), .y(y4), .out_valid(ov4)
    );

    multiplier #(.WORD_WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .a(a16), .b(b16), .y(y16), .out_valid(ov16)
    );

    // Model: the pair sampled at one edge appears after the next; y holds otherwise.
    bit              pv = 1'b0;
    bit              ev = 1'b0;
    longint unsigned pp [3] = '{0, 0, 0};
    longint unsigned ey [3] = '{0, 0, 0};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= 1'b0;
            ev <= 1'b0;
            pp <= '{0, 0, 0};
            ey <= '{0, 0, 0};
        end else begin
            ev <= pv;
            if (pv) ey <= pp;
            pv    <= in_valid;
            pp[0] <= 64'(a8) * 64'(b8);
            pp[1] <= 64'(a4) * 64'(b4);
            pp[2] <= 64'(a16) * 64'(b16);
        end
    end

    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ov8", 64'(ov8), 64'(ev));
            chk("y8", 64'(y8), ey[0]);
            chk("ov4", 64'(ov4), 64'(ev));
            chk("y4", 64'(y4), ey[1]);
            chk("ov16", 64'(ov16), 64'(ev));
            chk("y16", 64'(y16), ey[2]);
        end
    end

    task automatic step(bit v, logic [7:0] a, logic [7:0] b);
        in_valid = v;
        a8  = a;
        b8  = b;
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        @(negedge clk);
    endtask

    logic [7:0] ca [8] = '{8'd1, 8'd3, 8'd23, 8'd0, 8'd255, 8'd1, 8'd255, 8'd128};
    logic [7:0] cb [8] = '{8'd3, 8'd2, 8'd37, 8'd200, 8'd1, 8'd255, 8'd255, 8'd2};
    int         cy [8] = '{3, 6, 851, 0, 255, 255, 65025, 256};

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_y8", 64'(y8), 0);
        chk("rst_ov8", 64'(ov8), 0);
        @(negedge clk);
        cmp_en = 1'b1;
        #2 reset_n = 1'b1;

        // basic and corner operands, back to back
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(1'b1, ca[i], cb[i]);
            else step(1'b0, 8'd0, 8'd0);
            if (i > 0) begin
                chk($sformatf("lit_y%0d", i - 1), 64'(y8), 64'(cy[i-1]));
                chk($sformatf("lit_ov%0d", i - 1), 64'(ov8), 1);
            end
        end

        // bubbles
        step(1'b1, 8'd12, 8'd12);
        step(1'b0, 8'($urandom), 8'($urandom));
        chk("bub_y0", 64'(y8), 144);
        chk("bub_ov0", 64'(ov8), 1);
        step(1'b1, 8'd5, 8'd7);
        chk("bub_y1", 64'(y8), 144);
        chk("bub_ov1", 64'(ov8), 0);
        step(1'b0, 8'd0, 8'd0);
        chk("bub_y2", 64'(y8), 35);
        chk("bub_ov2", 64'(ov8), 1);

        // width extremes for the narrow and wide instances
        in_valid = 1'b1;
        a8  = 8'd2;
        b8  = 8'd2;
        a4  = 4'd15;
        b4  = 4'd15;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        @(negedge clk);
        step(1'b0, 8'd0, 8'd0);
        chk("w4_max", 64'(y4), 225);
        chk("w16_max", 64'(y16), 64'd4294836225);

        // reset with two pairs in flight
        step(1'b1, 8'd9, 8'd9);
        step(1'b1, 8'd10, 8'd10);
        @(posedge clk);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_y8", 64'(y8), 0);
        chk("mid_rst_ov8", 64'(ov8), 0);
        chk("mid_rst_y16", 64'(y16), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 8'd0);
            chk("post_rst_ov8", 64'(ov8), 0);
            chk("post_rst_y8", 64'(y8), 0);
        end

        // random soak
        repeat (10000) step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        step(1'b0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 8'd0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
